// File: rtl/cpu_pkg.sv
// Shared register-file constants and small types used by the write-back path
// and the register file itself.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Round-robin preference: which requester wins when both are valid.
    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } rr_pri_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. Grants are combinational; the preference
// pointer flips to the loser after every grant and holds otherwise.
module rr_arb2
    import cpu_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    rr_pri_e pri_reg;
    rr_pri_e pri_next;

    always_comb begin
        gnt_a = req_a && (!req_b || (pri_reg == PRI_A));
        gnt_b = req_b && (!req_a || (pri_reg == PRI_B));
    end

    always_comb begin
        pri_next = pri_reg;
        if (gnt_a) begin
            pri_next = PRI_B;
        end else if (gnt_b) begin
            pri_next = PRI_A;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pri_reg <= PRI_A;
        end else begin
            pri_reg <= pri_next;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between ALU (A) and load (B) write-backs
// and tracks destination registers with outstanding writes in a busy scoreboard.
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Issue_Valid,
    input  logic [ADDR_W-1:0]    Issue_Addr,
    input  logic                 A_Valid,
    input  logic [ADDR_W-1:0]    A_Addr,
    input  logic [DATA_W-1:0]    A_Data,
    output logic                 A_Ready,
    input  logic                 B_Valid,
    input  logic [ADDR_W-1:0]    B_Addr,
    input  logic [DATA_W-1:0]    B_Data,
    output logic                 B_Ready,
    output logic [ADDR_W-1:0]    W_Addr,
    output logic [DATA_W-1:0]    W_Data,
    output logic                 Write_Reg,
    output logic [2**ADDR_W-1:0] Busy
);

    localparam int NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic              wb_xfer;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_write;

    logic              write_reg_reg;
    logic [ADDR_W-1:0] w_addr_reg;
    logic [DATA_W-1:0] w_data_reg;

    logic [NREGS-1:1]  busy_reg;
    logic [NREGS-1:1]  busy_next;

    rr_arb2 u_arb (
        .Clk   (Clk),
        .Reset (Reset),
        .req_a (A_Valid),
        .req_b (B_Valid),
        .gnt_a (A_Ready),
        .gnt_b (B_Ready)
    );

    always_comb begin
        wb_xfer  = A_Ready || B_Ready;
        wb_addr  = B_Ready ? B_Addr : A_Addr;
        wb_data  = B_Ready ? B_Data : A_Data;
        wb_write = wb_xfer && (wb_addr != ZERO_ADDR);
    end

    // r0 transfers complete the handshake but never touch the write port.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            write_reg_reg <= 1'b0;
            w_addr_reg    <= '0;
            w_data_reg    <= '0;
        end else begin
            write_reg_reg <= wb_write;
            if (wb_write) begin
                w_addr_reg <= wb_addr;
                w_data_reg <= wb_data;
            end
        end
    end

    // A new reservation overrides a same-cycle write-back to the same register.
    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_busy
            logic set_bit;
            logic clr_bit;
            assign set_bit = Issue_Valid && (Issue_Addr == ADDR_W'(gi));
            assign clr_bit = wb_xfer && (wb_addr == ADDR_W'(gi));
            assign busy_next[gi] = set_bit || (busy_reg[gi] && !clr_bit);
        end
    endgenerate

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign Write_Reg = write_reg_reg;
    assign W_Addr    = w_addr_reg;
    assign W_Data    = w_data_reg;
    assign Busy      = {busy_reg, 1'b0};

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: requester queues drive the handshakes,
// accepted transfers push expected write-port results that are popped after the edge.
module tb_regfile_wb_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Issue_Valid;
    logic [4:0]  Issue_Addr;
    logic        A_Valid;
    logic [4:0]  A_Addr;
    logic [31:0] A_Data;
    logic        A_Ready;
    logic        B_Valid;
    logic [4:0]  B_Addr;
    logic [31:0] B_Data;
    logic        B_Ready;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic        Write_Reg;
    logic [31:0] Busy;

    regfile_wb_arbiter dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Issue_Valid (Issue_Valid),
        .Issue_Addr  (Issue_Addr),
        .A_Valid     (A_Valid),
        .A_Addr      (A_Addr),
        .A_Data      (A_Data),
        .A_Ready     (A_Ready),
        .B_Valid     (B_Valid),
        .B_Addr      (B_Addr),
        .B_Data      (B_Data),
        .B_Ready     (B_Ready),
        .W_Addr      (W_Addr),
        .W_Data      (W_Data),
        .Write_Reg   (Write_Reg),
        .Busy        (Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } req_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    req_t a_q[$];
    req_t b_q[$];
    wb_t  wb_q[$];
    logic [4:0] seen_q[$];

    logic        exp_pri;
    logic [31:0] exp_busy;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at posedge+1, check Ready at negedge, check outputs at posedge+1.
    task automatic step(input logic iv, input logic [4:0] ia);
        logic ga, gb, xfer;
        req_t r;
        wb_t  w;
        Issue_Valid = iv;
        Issue_Addr  = ia;
        A_Valid = (a_q.size() != 0);
        B_Valid = (b_q.size() != 0);
        if (A_Valid) begin
            A_Addr = a_q[0].addr;
            A_Data = a_q[0].data;
        end
        if (B_Valid) begin
            B_Addr = b_q[0].addr;
            B_Data = b_q[0].data;
        end
        @(negedge Clk);
        ga = A_Valid && (!B_Valid || !exp_pri);
        gb = B_Valid && (!A_Valid || exp_pri);
        check("a_ready", {31'd0, A_Ready}, {31'd0, ga});
        check("b_ready", {31'd0, B_Ready}, {31'd0, gb});
        xfer = ga || gb;
        r = '0;
        if (ga) r = a_q.pop_front();
        if (gb) r = b_q.pop_front();
        if (xfer) begin
            w.we   = (r.addr != 5'd0);
            w.addr = r.addr;
            w.data = r.data;
            wb_q.push_back(w);
            exp_pri = ga;
        end
        @(posedge Clk);
        #1;
        if (xfer) exp_busy[r.addr] = 1'b0;
        if (iv) exp_busy[ia] = 1'b1;
        exp_busy[0] = 1'b0;
        check("busy", Busy, exp_busy);
        if (wb_q.size() != 0) begin
            w = wb_q.pop_front();
            check("write_reg", {31'd0, Write_Reg}, {31'd0, w.we});
            if (w.we) begin
                check("w_addr", {27'd0, W_Addr}, {27'd0, w.addr});
                check("w_data", W_Data, w.data);
            end
        end else begin
            check("write_reg_idle", {31'd0, Write_Reg}, 32'd0);
        end
        if (Write_Reg) seen_q.push_back(W_Addr);
        $display("step t=%0t iss=%0b/%0d a=%0b b=%0b we=%0b w_addr=%0d busy=%08h",
                 $time, iv, ia, ga, gb, Write_Reg, W_Addr, Busy);
    endtask

    task automatic push_a(input logic [4:0] addr, input logic [31:0] data);
        req_t r;
        r.addr = addr;
        r.data = data;
        a_q.push_back(r);
    endtask

    task automatic push_b(input logic [4:0] addr, input logic [31:0] data);
        req_t r;
        r.addr = addr;
        r.data = data;
        b_q.push_back(r);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},   {31'd0, Write_Reg}, 32'd0);
        check({tag, "_addr"}, {27'd0, W_Addr}, 32'd0);
        check({tag, "_data"}, W_Data, 32'd0);
        check({tag, "_busy"}, Busy, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        Issue_Valid = 1'b0; Issue_Addr = '0;
        A_Valid = 1'b0; A_Addr = '0; A_Data = '0;
        B_Valid = 1'b0; B_Addr = '0; B_Data = '0;
        exp_pri = 1'b0;
        exp_busy = '0;
        repeat (2) @(posedge Clk);
        #1;
        check_reset_outputs("por");
        #2 Reset = 1'b0;
        @(posedge Clk);
        #1;

        // Single requester with a reservation first
        step(1'b1, 5'd5);
        push_a(5'd5, 32'h0000_1234);
        step(1'b0, 5'd0);
        step(1'b0, 5'd0);

        // r0 write from B: handshake only; also restores A preference
        push_b(5'd0, 32'hFFFF_FFFF);
        step(1'b0, 5'd0);
        step(1'b0, 5'd0);

        // Contention: expected order A1, B3, A2, B4
        for (int i = 1; i <= 4; i++) step(1'b1, 5'(i));
        seen_q.delete();
        push_a(5'd1, 32'hA000_0001);
        push_a(5'd2, 32'hA000_0002);
        push_b(5'd3, 32'hB000_0003);
        push_b(5'd4, 32'hB000_0004);
        repeat (5) step(1'b0, 5'd0);
        check("order_len", seen_q.size(), 32'd4);
        if (seen_q.size() == 4) begin
            check("order0", {27'd0, seen_q[0]}, 32'd1);
            check("order1", {27'd0, seen_q[1]}, 32'd3);
            check("order2", {27'd0, seen_q[2]}, 32'd2);
            check("order3", {27'd0, seen_q[3]}, 32'd4);
        end

        // Scoreboard: set, same-cycle set+clear, different-bit set+clear, plain clear
        step(1'b1, 5'd7);
        push_a(5'd7, 32'h0000_0777);
        step(1'b1, 5'd7);
        push_a(5'd7, 32'h0000_0778);
        step(1'b1, 5'd9);
        push_b(5'd9, 32'h0000_0999);
        step(1'b0, 5'd0);
        step(1'b0, 5'd0);

        // Reset mid-stream under continuous dual traffic
        for (int i = 0; i < 6; i++) begin
            push_a(5'(10 + i), 32'hC000_0000 | i);
            push_b(5'(20 + i), 32'hD000_0000 | i);
        end
        step(1'b1, 5'd12);
        step(1'b1, 5'd21);
        step(1'b0, 5'd0);
        #2 Reset = 1'b1;
        #1;
        check_reset_outputs("async");
        a_q.delete();
        b_q.delete();
        wb_q.delete();
        exp_pri = 1'b0;
        exp_busy = '0;
        A_Valid = 1'b0;
        B_Valid = 1'b0;
        Issue_Valid = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        check("post_reset_we", {31'd0, Write_Reg}, 32'd0);
        step(1'b0, 5'd0);
        seen_q.delete();
        push_a(5'd6, 32'h0000_0066);
        push_b(5'd8, 32'h0000_0088);
        step(1'b0, 5'd0);
        step(1'b0, 5'd0);
        step(1'b0, 5'd0);
        check("first_after_reset", (seen_q.size() != 0) ? {27'd0, seen_q[0]} : 32'hFFFF_FFFF, 32'd6);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            if (a_q.size() == 0 && $urandom_range(0, 2) != 0)
                push_a(5'($urandom_range(0, 31)), $urandom);
            if (b_q.size() == 0 && $urandom_range(0, 2) != 0)
                push_b(5'($urandom_range(0, 31)), $urandom);
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end
        while (a_q.size() != 0 || b_q.size() != 0) step(1'b0, 5'd0);
        step(1'b0, 5'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
